// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the HDMI output path.
// Produces registered hsync/vsync/de, pixel coordinates and line/frame strobes
// from free-running horizontal and vertical counters on the pixel clock.
// Optional build macro: VTG_TEST_PATTERN_EN adds r/g/b ports carrying an
// 8-bar colour test pattern aligned with de/x/y.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        pll_lock,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start
`ifdef VTG_TEST_PATTERN_EN
    ,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = 12;
    localparam int unsigned V_W     = 11;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    // Elaboration-time guard against unsupported timing parameters
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_param_check
        $error("video_timing_gen: timing parameters out of supported range");
    end

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic [H_W-1:0] x_q, x_d;
    logic [V_W-1:0] y_q, y_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;
    logic           sync_rst;

    assign sync_rst = rst || !pll_lock;

    // Counter advance: h wraps every line, v steps on the h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + H_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
        end
    end

    // Decode of the current counter position into next output values
    always_comb begin
        de_d          = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        hsync_d       = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d       = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
        x_d           = de_d ? h_cnt_q : '0;
        y_d           = de_d ? v_cnt_q : '0;
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

`ifdef VTG_TEST_PATTERN_EN
    logic [23:0] rgb_q, rgb_d;
    logic [2:0]  bar;

    // First column of bar k: ceil(k * H_ACTIVE / 8), folded to a constant
    function automatic logic [H_W-1:0] bar_thr(input int unsigned k);
        return H_W'((k * H_ACTIVE + 7) / 8);
    endfunction

    // Bar index by threshold compares, then colour lookup
    always_comb begin
        bar = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_cnt_q >= bar_thr(k)) begin
                bar = bar + 3'd1;
            end
        end
        unique case (bar)
            3'd0:    rgb_d = 24'hFFFFFF;
            3'd1:    rgb_d = 24'hFFFF00;
            3'd2:    rgb_d = 24'h00FFFF;
            3'd3:    rgb_d = 24'h00FF00;
            3'd4:    rgb_d = 24'hFF00FF;
            3'd5:    rgb_d = 24'hFF0000;
            3'd6:    rgb_d = 24'h0000FF;
            default: rgb_d = 24'h000000;
        endcase
        if (!de_d) begin
            rgb_d = '0;
        end
    end

    // Pattern register, cleared with the raster
    always_ff @(posedge clk_in) begin
        if (sync_rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign r = rgb_q[23:16];
    assign g = rgb_q[15:8];
    assign b = rgb_q[7:0];
`endif

    // Counter and output registers; reset or lost PLL lock restarts the raster
    always_ff @(posedge clk_in) begin
        if (sync_rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: a 1080p instance and a small negative-polarity
// instance share clock, reset and lock. The driver pushes expected outputs from
// a linear-position reference model; a negedge monitor pops and compares.
module tb_video_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } obs_t;

    localparam int BIG_PER   = 2200 * 1125;
    localparam int SMALL_PER = 14 * 7;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;

    logic        b_hs, b_vs, b_de, b_ls, b_fs;
    logic [11:0] b_x;
    logic [10:0] b_y;
    logic        s_hs, s_vs, s_de, s_ls, s_fs;
    logic [11:0] s_x;
    logic [10:0] s_y;
`ifdef VTG_TEST_PATTERN_EN
    logic [7:0]  b_r, b_g, b_b, s_r, s_g, s_b;
`endif

    obs_t q_big[$];
    obs_t q_small[$];
    int   pos_big   = 0;
    int   pos_small = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    video_timing_gen u_big (
        .clk_in(clk), .rst(rst), .pll_lock(pll_lock),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs)
`ifdef VTG_TEST_PATTERN_EN
        , .r(b_r), .g(b_g), .b(b_b)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_small (
        .clk_in(clk), .rst(rst), .pll_lock(pll_lock),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VTG_TEST_PATTERN_EN
        , .r(s_r), .g(s_g), .b(s_b)
`endif
    );

    // Expected outputs for raster position pos (pos < 0 means reset)
    function automatic obs_t ref_model(input int pos, input int ha, input int hf,
                                       input int hsw, input int hb, input int va,
                                       input int vf, input int vsw, input int vb,
                                       input bit hp, input bit vp);
        obs_t o;
        int ht, h, v, bar;
        logic [23:0] pal [8];
        pal[0] = 24'hFFFFFF; pal[1] = 24'hFFFF00; pal[2] = 24'h00FFFF; pal[3] = 24'h00FF00;
        pal[4] = 24'hFF00FF; pal[5] = 24'hFF0000; pal[6] = 24'h0000FF; pal[7] = 24'h000000;
        o = '0;
        if (pos < 0) begin
            o.hs = ~hp;
            o.vs = ~vp;
            return o;
        end
        ht = ha + hf + hsw + hb;
        h  = pos % ht;
        v  = pos / ht;
        o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
        o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
        o.de = (h < ha) && (v < va);
        o.x  = o.de ? 12'(h) : 12'd0;
        o.y  = o.de ? 11'(v) : 11'd0;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
`ifdef VTG_TEST_PATTERN_EN
        if (o.de) begin
            bar   = (h * 8) / ha;
            o.rgb = pal[bar];
        end
`else
        bar = 0;
        o.rgb = pal[7] & 24'h000000;
`endif
        return o;
    endfunction

    function automatic obs_t exp_big(input int pos);
        return ref_model(pos, 1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1);
    endfunction

    function automatic obs_t exp_small(input int pos);
        return ref_model(pos, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0);
    endfunction

    // One clock with the given inputs; expectation queued after the edge
    task automatic step(input logic r_i, input logic l_i);
        rst      = r_i;
        pll_lock = l_i;
        @(posedge clk);
        if (r_i || !l_i) begin
            q_big.push_back(exp_big(-1));
            q_small.push_back(exp_small(-1));
            pos_big   = 0;
            pos_small = 0;
        end else begin
            q_big.push_back(exp_big(pos_big));
            q_small.push_back(exp_small(pos_small));
            pos_big   = (pos_big + 1) % BIG_PER;
            pos_small = (pos_small + 1) % SMALL_PER;
        end
        #1;
    endtask

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h, want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h",
                     name, $time, got.hs, got.vs, got.de, got.x, got.y, got.ls, got.fs, got.rgb,
                     want.hs, want.vs, want.de, want.x, want.y, want.ls, want.fs, want.rgb);
        end
    endtask

    // Monitor: pop one expectation per instance each cycle, away from the edge
    always @(negedge clk) begin
        obs_t a, e;
        if (q_big.size() > 0) begin
            e = q_big.pop_front();
            a = '{hs: b_hs, vs: b_vs, de: b_de, x: b_x, y: b_y, ls: b_ls, fs: b_fs, rgb: 24'h0};
`ifdef VTG_TEST_PATTERN_EN
            a.rgb = {b_r, b_g, b_b};
`endif
            check("big", a, e);
        end
        if (q_small.size() > 0) begin
            e = q_small.pop_front();
            a = '{hs: s_hs, vs: s_vs, de: s_de, x: s_x, y: s_y, ls: s_ls, fs: s_fs, rgb: 24'h0};
`ifdef VTG_TEST_PATTERN_EN
            a.rgb = {s_r, s_g, s_b};
`endif
            check("small", a, e);
        end
    end

    initial begin
        int cyc;
        int n;
        int ev;
        int guard;

        // Reset, then reset together with lock low
        repeat (3) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Clean run past a full 1080p line
        repeat (2300) step(1'b0, 1'b1);

        // Lock drop mid-line at column 100, held 3 cycles, then relock
        guard = 0;
        while ((pos_big % 2200) != 100 && guard < 2200) begin
            step(1'b0, 1'b1);
            guard++;
        end
        repeat (3) step(1'b0, 1'b0);
        repeat (2300) step(1'b0, 1'b1);

        // Random reset / lock disturbances
        cyc = 0;
        while (cyc < 8000) begin
            if ($urandom % 300 == 0) begin
                n  = $urandom_range(1, 4);
                ev = $urandom_range(0, 2);
                repeat (n) begin
                    case (ev)
                        0:       step(1'b1, 1'b1);
                        1:       step(1'b0, 1'b0);
                        default: step(1'b1, 1'b0);
                    endcase
                end
                cyc += n;
            end else begin
                step(1'b0, 1'b1);
                cyc++;
            end
        end

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (q_big.size() != 0 || q_small.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q_big.size(), q_small.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
